// File: rtl/char_grid_writer.sv
// Double-buffered character grid: upstream writes glyphs into a back grid,
// COMMIT copies back to the displayed front grid on the next vsync fall.
module char_grid_writer #(
    parameter int COLS   = 10,
    parameter int ROWS   = 2,
    parameter int CODE_W = 6,
    localparam int XW    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int YW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                                clk50,
    input  logic                                reset_n,
    input  logic                                in_valid,
    input  logic [7:0]                          in_data,
    output logic                                in_ready,
    input  logic                                vsync_n,
    output logic [COLS-1:0][ROWS-1:0][CODE_W-1:0] frame_buffer,
    output logic [XW-1:0]                       cursor_x,
    output logic [YW-1:0]                       cursor_y,
    output logic                                commit_pending
);

    typedef enum logic [1:0] {IDLE, CLEAR, WAIT_SWAP} state_t;

    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    state_t                                state;
    logic [COLS-1:0][ROWS-1:0][CODE_W-1:0] back;
    logic [XW-1:0]                         clr_x;
    logic [YW-1:0]                         clr_y;
    logic                                  vs_d;
    logic [XW-1:0]                         adv_x;
    logic [YW-1:0]                         adv_y;
    logic [YW-1:0]                         row_next;
    logic                                  take;
    logic                                  frame_edge;

    assign take       = in_valid && in_ready;
    assign frame_edge = vs_d && !vsync_n;

    // Explicit compare-and-wrap keeps non-power-of-two sizes modulo-correct
    always_comb begin
        row_next = (cursor_y == Y_LAST) ? '0 : cursor_y + 1'b1;
        adv_x    = cursor_x + 1'b1;
        adv_y    = cursor_y;
        if (cursor_x == X_LAST) begin
            adv_x = '0;
            adv_y = row_next;
        end
    end

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            state          <= IDLE;
            back           <= '0;
            frame_buffer   <= '0;
            cursor_x       <= '0;
            cursor_y       <= '0;
            clr_x          <= '0;
            clr_y          <= '0;
            commit_pending <= 1'b0;
            vs_d           <= 1'b1;
            in_ready       <= 1'b0;
        end else begin
            vs_d <= vsync_n;
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (take && !in_data[7]) begin
                        back[cursor_x][cursor_y] <= in_data[CODE_W-1:0];
                        cursor_x <= adv_x;
                        cursor_y <= adv_y;
                    end else if (take && in_data[6:2] == 5'd0) begin
                        unique case (in_data[1:0])
                            2'd0: begin
                                state    <= CLEAR;
                                in_ready <= 1'b0;
                                clr_x    <= '0;
                                clr_y    <= '0;
                                cursor_x <= '0;
                                cursor_y <= '0;
                            end
                            2'd1: begin
                                cursor_x <= '0;
                                cursor_y <= row_next;
                            end
                            2'd2: begin
                                cursor_x <= '0;
                                cursor_y <= '0;
                            end
                            default: begin
                                state          <= WAIT_SWAP;
                                in_ready       <= 1'b0;
                                commit_pending <= 1'b1;
                            end
                        endcase
                    end
                end
                CLEAR: begin
                    // Column-major sweep: y runs fastest within each column
                    back[clr_x][clr_y] <= '0;
                    if (clr_y == Y_LAST) begin
                        clr_y <= '0;
                        if (clr_x == X_LAST) begin
                            clr_x    <= '0;
                            state    <= IDLE;
                            in_ready <= 1'b1;
                        end else begin
                            clr_x <= clr_x + 1'b1;
                        end
                    end else begin
                        clr_y <= clr_y + 1'b1;
                    end
                end
                WAIT_SWAP: begin
                    if (frame_edge) begin
                        frame_buffer   <= back;
                        commit_pending <= 1'b0;
                        state          <= IDLE;
                        in_ready       <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_grid_writer.sv
// Directed bench for char_grid_writer: glyph writes, cursor wrap,
// commit/swap timing, clear timing, command decode and reset abort.
module tb_char_grid_writer;

    logic                  clk50 = 1'b0;
    logic                  reset_n;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  vsync_n;
    logic [9:0][1:0][5:0]  frame_buffer;
    logic [3:0]            cursor_x;
    logic [0:0]            cursor_y;
    logic                  commit_pending;

    logic [9:0][1:0][5:0]  exp_fb;
    int                    checks = 0;
    int                    errors = 0;
    int                    n;

    char_grid_writer dut (
        .clk50          (clk50),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .vsync_n        (vsync_n),
        .frame_buffer   (frame_buffer),
        .cursor_x       (cursor_x),
        .cursor_y       (cursor_y),
        .commit_pending (commit_pending)
    );

    always #10 clk50 = ~clk50;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cur(input string tag, input int x, input int y);
        chk(tag, 128'({cursor_x, cursor_y}), 128'({4'(x), 1'(y)}));
    endtask

    task automatic chk_fb(input string tag);
        chk(tag, 128'(frame_buffer), 128'(exp_fb));
    endtask

    // Present one byte, wait (bounded) for in_ready, return #1 after transfer
    task automatic send(input logic [7:0] b);
        int k;
        @(negedge clk50);
        in_valid = 1'b1;
        in_data  = b;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk50);
            k++;
        end
        if (k == 100) chk("send_timeout", 128'(in_ready), 128'(1));
        @(posedge clk50);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic vsync_fall;
        @(negedge clk50);
        vsync_n = 1'b0;
        @(posedge clk50);
        #1;
        @(negedge clk50);
        vsync_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        vsync_n  = 1'b1;
        exp_fb   = '0;
        repeat (3) @(posedge clk50);
        @(negedge clk50);
        chk("rst_ready", 128'(in_ready), 128'(0));
        chk("rst_pending", 128'(commit_pending), 128'(0));
        chk_fb("rst_fb");
        chk_cur("rst_cursor", 0, 0);
        reset_n = 1'b1;
        @(posedge clk50);
        #1;
        chk("ready_after_rst", 128'(in_ready), 128'(1));

        // Three glyphs then commit and swap
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk_cur("cursor_3_0", 3, 0);
        send(8'h83);
        chk("commit_pending", 128'(commit_pending), 128'(1));
        chk("commit_not_ready", 128'(in_ready), 128'(0));
        chk_fb("fb_before_swap");
        vsync_fall();
        exp_fb[0][0] = 6'd1;
        exp_fb[1][0] = 6'd2;
        exp_fb[2][0] = 6'd3;
        chk_fb("fb_swap_123");
        chk("pending_cleared", 128'(commit_pending), 128'(0));
        chk_cur("cursor_kept", 3, 0);

        // Row wrap; 0x46 also exercises truncation to 6 bits
        send(8'h82);
        for (int i = 0; i < 10; i++) send(8'h05);
        chk_cur("wrap_row", 0, 1);
        send(8'h46);
        chk_cur("after_wrap", 1, 1);
        chk_fb("fb_no_commit");

        // Commit coincident with vsync fall must not swap on that edge
        @(negedge clk50);
        in_valid = 1'b1;
        in_data  = 8'h83;
        vsync_n  = 1'b0;
        @(posedge clk50);
        #1;
        in_valid = 1'b0;
        chk("coinc_pending", 128'(commit_pending), 128'(1));
        chk_fb("coinc_no_swap");
        @(negedge clk50);
        vsync_n = 1'b1;
        repeat (2) @(posedge clk50);
        #1;
        chk("still_pending", 128'(commit_pending), 128'(1));
        vsync_fall();
        for (int x = 0; x < 10; x++) exp_fb[x][0] = 6'd5;
        exp_fb[0][1] = 6'd6;
        chk_fb("fb_swap_wrap");

        // Newline, home and an ignored command
        send(8'h07);
        send(8'h07);
        send(8'h07);
        chk_cur("cursor_4_1", 4, 1);
        send(8'h81);
        chk_cur("newline_wrap", 0, 0);
        for (int i = 0; i < 7; i++) send(8'h08);
        chk_cur("cursor_7_0", 7, 0);
        send(8'h82);
        chk_cur("home", 0, 0);
        send(8'h09);
        send(8'h9C);
        chk_cur("ignored_cmd", 1, 0);
        chk("ignored_ready", 128'(in_ready), 128'(1));
        chk("ignored_pending", 128'(commit_pending), 128'(0));

        // Fill the whole grid, commit, then clear
        send(8'h82);
        for (int i = 0; i < 20; i++) send(8'(40 + i));
        chk_cur("full_wrap", 0, 0);
        send(8'h83);
        vsync_fall();
        for (int i = 0; i < 20; i++) exp_fb[i % 10][i / 10] = 6'(40 + i);
        chk_fb("fb_full");
        send(8'h85);
        send(8'h80);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk50);
            #1;
            n++;
        end
        chk("clear_cycles", 128'(n), 128'(20));
        chk_fb("fb_kept_on_clear");
        chk_cur("clear_home", 0, 0);
        send(8'h83);
        vsync_fall();
        exp_fb = '0;
        chk_fb("fb_cleared");

        // Reset in the middle of WAIT_SWAP aborts the commit
        send(8'h15);
        send(8'h83);
        chk("pre_abort_pending", 128'(commit_pending), 128'(1));
        @(negedge clk50);
        reset_n = 1'b0;
        @(negedge clk50);
        reset_n = 1'b1;
        vsync_fall();
        chk_fb("abort_fb");
        chk("abort_ready", 128'(in_ready), 128'(1));
        chk("abort_pending", 128'(commit_pending), 128'(0));
        chk_cur("abort_cursor", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/char_grid_writer.md
CHAR_GRID_WRITER -- requirements
Module: char_grid_writer

Interface
REQ-001 The block SHALL have parameter COLS, default 10, meaning the number of grid columns.
REQ-002 The block SHALL have parameter ROWS, default 2, meaning the number of grid rows.
REQ-003 The block SHALL have parameter CODE_W, default 6, meaning the glyph code width; code 0 means blank.
REQ-004 Port clk50  input  1  sole clock, with all state on its rising edge.
REQ-005 Port reset_n  input  1  reset, synchronous and active-low.
REQ-006 Port in_valid  input  1  upstream presents a byte.
REQ-007 Port in_data  input  8  byte: bit7=0 means glyph (bits CODE_W-1:0 are the code); bit7=1 means command (bits 1:0 are the opcode).
REQ-008 Port in_ready  output  1  block accepts in_data this cycle.
REQ-009 Port vsync_n  input  1  display vertical sync, active-low, asynchronous to nothing (same clk50 domain).
REQ-010 Port frame_buffer  output  [COLS-1:0][ROWS-1:0] x CODE_W  front grid, indexed [x][y], driven straight from registers.
REQ-011 Port cursor_x  output  clog2(COLS)  current write column.
REQ-012 Port cursor_y  output  clog2(ROWS)  current write row.
REQ-013 Port commit_pending  output  1  high while a commit waits for a frame boundary.

Function
REQ-014 The block SHALL hold two grids: back (written by upstream) and front (driven on frame_buffer).
REQ-015 A transfer SHALL occur only in a cycle where in_valid and in_ready are both high; in_ready SHALL be high only in state IDLE.
REQ-016 The state machine SHALL have three states: IDLE, CLEAR and WAIT_SWAP.
REQ-017 On a glyph transfer, back[cursor_x][cursor_y] SHALL take the code at the same clock edge, and the cursor SHALL advance by one column.
REQ-018 Cursor advance past column COLS-1 SHALL wrap to column 0 of the next row; past (COLS-1,ROWS-1) it SHALL wrap to (0,0).
REQ-019 Command opcode 0 (CLEAR) SHALL move the block to CLEAR, zero one back cell per cycle in column-major order (COLS*ROWS cycles), home the cursor, then return to IDLE.
REQ-020 Command opcode 1 (NEWLINE) SHALL set cursor_x to 0 and advance cursor_y by 1, wrapping from ROWS-1 to 0, in one cycle, with no back write.
REQ-021 Command opcode 2 (HOME) SHALL set the cursor to (0,0) in one cycle.
REQ-022 Command opcode 3 (COMMIT) SHALL move the block to WAIT_SWAP and raise commit_pending on the next cycle.
REQ-023 The block SHALL register vsync_n into vs_d every cycle; a frame edge is vs_d==1 and vsync_n==0.
REQ-024 In WAIT_SWAP, at the clock edge where a frame edge is true, front SHALL be loaded with all of back in one cycle, commit_pending SHALL drop, and the state SHALL return to IDLE.
REQ-025 Back SHALL be unchanged by a swap, so later glyphs edit a copy of the displayed frame.
REQ-026 A frame edge coincident with COMMIT acceptance SHALL NOT swap; the swap SHALL occur on the next frame edge.
REQ-027 Front SHALL change only on a swap; glyph, CLEAR, NEWLINE and HOME SHALL never alter frame_buffer directly.
REQ-028 Glyph codes SHALL be truncated to CODE_W bits; in_data bits 6:CODE_W SHALL be ignored.
REQ-029 A command with in_data bits 6:2 nonzero SHALL be accepted and ignored (no state change).
REQ-030 Cursor arithmetic SHALL be modulo COLS and ROWS, including for non-power-of-two values.

Reset
REQ-031 While reset_n is low at a rising edge, both grids SHALL become all zero, cursor (0,0), state IDLE, commit_pending 0 and vs_d 1.
REQ-032 in_ready SHALL be 0 during reset cycles and 1 on the first cycle after reset_n is sampled high.
REQ-033 Reset asserted during CLEAR or WAIT_SWAP SHALL abort the operation with no partial swap.

Verification
REQ-034 Reset, then glyphs 1,2,3, then COMMIT, then drive vsync_n 1->0 -> frame_buffer[0][0]=1, [1][0]=2, [2][0]=3, all other cells 0, cursor (3,0).
REQ-035 Send 10 glyphs of 5, then 1 glyph of 6 -> cursor wraps to (0,1) and then reads (1,1); back[0][1]=6; frame_buffer stays all 0 until a commit.
REQ-036 Send COMMIT while vsync_n is falling in the same cycle -> no swap on that edge; commit_pending=1; swap on the following falling edge.
REQ-037 Fill the grid, COMMIT and swap, then send CLEAR -> in_ready=0 for exactly 20 cycles; front is still the full grid; the next COMMIT and swap gives all zero.
REQ-038 Send NEWLINE from (4,1) -> cursor (0,0); send HOME from (7,0) -> cursor (0,0); send command 0x9C -> no change.
REQ-039 Pulse reset_n low mid-WAIT_SWAP -> the next frame edge causes no swap; frame_buffer is all zero; in_ready=1.
